hazard_unit: RTL and testbench

- Stall/flush controller for the 5-stage pipeline; the counterpart of the forwarding unit. Forwarding resolves hazards by bypassing data. This block resolves the hazards that forwarding cannot: it freezes, bubbles or flushes pipeline latches and the PC.
- Covers load-use, data-memory wait, instruction-fetch wait and taken branch/jump resolved in MEM.
- Holds a small FSM, a deferred-flush flag and saturating performance counters.

---
 rtl/hazard_unit.sv | 132 +++++++++++++
 tb/tb_hazard_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// ============================================================================
// hazard_unit : stall/flush controller for the 5-stage pipeline
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rsel1,
  input  logic [4:0]       id_rsel2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_wsel,
  input  logic             ex_wen,
  input  logic             ex_memToReg,
  input  logic             mem_dreq,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             mem_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LU    = 2'd1,
    DWAIT = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             flush_evt;
  logic             lu_hz;
  logic             dw_hz;

  assign lu_hz = ex_memToReg && ex_wen && (ex_wsel != 5'd0) &&
                 ((ex_wsel == id_rsel1) || (id_uses_rs2 && (ex_wsel == id_rsel2)));
  assign dw_hz = mem_dreq && !dhit;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    state_d     = RUN;
    pend_d      = pend_q;
    flush_evt   = 1'b0;

    if (RST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      pend_d      = 1'b0;
    end else if (dw_hz) begin
      // A branch resolving during the wait is remembered and flushed once MEM completes.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      memwb_flush = 1'b1;
      state_d     = DWAIT;
      pend_d      = pend_q | mem_br_taken;
    end else if (mem_br_taken || pend_q) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = FLUSH;
      pend_d      = 1'b0;
      flush_evt   = 1'b1;
    end else if (lu_hz && (state_q != LU)) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
      state_d     = LU;
    end else if (!ihit) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (!pc_en && (stall_cnt_q != CNT_MAX))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != CNT_MAX))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz_state  = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// tb_hazard_unit : directed + randomized check of hazard_unit against a model
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hazard_unit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic [4:0] id_rsel1, id_rsel2, ex_wsel;
  logic       id_uses_rs2, ex_wen, ex_memToReg, mem_dreq, dhit, ihit, mem_br_taken;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0]  hz_state;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
  logic        ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4;
  logic [1:0]  hz_state4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  hazard_unit #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .id_rsel1(id_rsel1), .id_rsel2(id_rsel2),
    .id_uses_rs2(id_uses_rs2), .ex_wsel(ex_wsel), .ex_wen(ex_wen),
    .ex_memToReg(ex_memToReg), .mem_dreq(mem_dreq), .dhit(dhit), .ihit(ihit),
    .mem_br_taken(mem_br_taken), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .hz_state(hz_state), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .id_rsel1(id_rsel1), .id_rsel2(id_rsel2),
    .id_uses_rs2(id_uses_rs2), .ex_wsel(ex_wsel), .ex_wen(ex_wen),
    .ex_memToReg(ex_memToReg), .mem_dreq(mem_dreq), .dhit(dhit), .ihit(ihit),
    .mem_br_taken(mem_br_taken), .pc_en(pc_en4), .ifid_en(ifid_en4),
    .idex_en(idex_en4), .exmem_en(exmem_en4), .memwb_en(memwb_en4),
    .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .exmem_flush(exmem_flush4),
    .memwb_flush(memwb_flush4), .hz_state(hz_state4), .stall_cnt(stall_cnt4),
    .flush_cnt(flush_cnt4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: what the pipeline did last cycle, a remembered branch, raw event counts.
  int     m_state = 0;
  bit     m_pend  = 1'b0;
  longint m_sc    = 0;
  longint m_fc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 reset, 1 data wait, 2 branch flush, 3 load-use bubble, 4 fetch wait, 5 free flow
  function automatic int decide();
    bit lu;
    lu = ex_memToReg && ex_wen && (ex_wsel != 0) &&
         ((ex_wsel == id_rsel1) || (id_uses_rs2 && ex_wsel == id_rsel2));
    if (RST) return 0;
    if (mem_dreq && !dhit) return 1;
    if (mem_br_taken || m_pend) return 2;
    if (lu && m_state != 1) return 3;
    if (!ihit) return 4;
    return 5;
  endfunction

  // Vector order: pc, ifid, idex, exmem, memwb enables, then ifid, idex, exmem, memwb flushes.
  function automatic void expect_ctl(input int c, output logic [8:0] e, output logic [8:0] care);
    care = 9'h1FF;
    case (c)
      0: e = 9'b00000_1111;
      1: e = 9'b00000_0001;
      2: e = 9'b11111_1110;
      3: begin e = 9'b00111_0100; care[6] = 1'b0; end
      4: begin e = 9'b01111_1000; care[7] = 1'b0; end
      default: e = 9'b11111_0000;
    endcase
  endfunction

  always @(posedge CLK) begin
    int c;
    c = decide();
    if (c == 0) begin
      m_state = 0; m_pend = 1'b0; m_sc = 0; m_fc = 0;
    end else begin
      if (c == 1 || c == 3 || c == 4) m_sc++;
      if (c == 2) m_fc++;
      if (c == 1) m_pend = m_pend | mem_br_taken;
      if (c == 2) m_pend = 1'b0;
      m_state = (c == 1) ? 2 : (c == 2) ? 3 : (c == 3) ? 1 : 0;
    end
  end

  always @(negedge CLK) begin
    logic [8:0] e, care;
    if (chk_en) begin
      expect_ctl(decide(), e, care);
      chk("ctl", 64'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, memwb_flush} & care), 64'(e & care));
      chk("ctl4", 64'({pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4,
                       ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4} & care), 64'(e & care));
      chk("hz_state", 64'(hz_state), 64'(m_state));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_fc));
      chk("stall_cnt4", 64'(stall_cnt4), 64'((m_sc > 15) ? 15 : m_sc));
      chk("flush_cnt4", 64'(flush_cnt4), 64'((m_fc > 15) ? 15 : m_fc));
    end
  end

  task automatic quiet();
    RST = 1'b0; id_rsel1 = 5'd0; id_rsel2 = 5'd0; id_uses_rs2 = 1'b0;
    ex_wsel = 5'd0; ex_wen = 1'b0; ex_memToReg = 1'b0;
    mem_dreq = 1'b0; dhit = 1'b0; ihit = 1'b1; mem_br_taken = 1'b0;
  endtask

  task automatic nxt();
    @(posedge CLK); #1; quiet();
  endtask

  task automatic smp();
    @(negedge CLK); #1;
  endtask

  task automatic do_reset();
    nxt(); RST = 1'b1;
  endtask

  task automatic load_to(input logic [4:0] w);
    ex_memToReg = 1'b1; ex_wen = 1'b1; ex_wsel = w;
  endtask

  initial begin
    quiet(); RST = 1'b1;
    nxt(); RST = 1'b1; chk_en = 1'b1;
    smp(); chk("rst_pc_en", 64'(pc_en), 64'd0); chk("rst_memwb_flush", 64'(memwb_flush), 64'd1);
    nxt();
    smp(); chk("rel_state", 64'(hz_state), 64'd0); chk("rel_pc_en", 64'(pc_en), 64'd1);
    chk("rel_ifid_flush", 64'(ifid_flush), 64'd0); chk("rel_stall", 64'(stall_cnt), 64'd0);

    nxt(); load_to(5'd8); id_rsel1 = 5'd8;
    smp(); chk("lu_pc_en", 64'(pc_en), 64'd0); chk("lu_ifid_en", 64'(ifid_en), 64'd0);
    chk("lu_idex_flush", 64'(idex_flush), 64'd1); chk("lu_exmem_en", 64'(exmem_en), 64'd1);
    nxt();
    smp(); chk("lu_next_state", 64'(hz_state), 64'd1); chk("lu_next_pc", 64'(pc_en), 64'd1);
    chk("lu_stall", 64'(stall_cnt), 64'd1);
    nxt();
    smp(); chk("lu_back_run", 64'(hz_state), 64'd0);

    nxt(); load_to(5'd5); id_rsel1 = 5'd5;
    nxt(); load_to(5'd6); id_rsel1 = 5'd6;
    smp(); chk("lu_masked_pc", 64'(pc_en), 64'd1); chk("lu_masked_stall", 64'(stall_cnt), 64'd2);

    nxt(); load_to(5'd0);
    smp(); chk("r0_no_stall", 64'(pc_en), 64'd1);
    nxt(); load_to(5'd9); id_rsel1 = 5'd3; id_rsel2 = 5'd9;
    smp(); chk("rt_gated", 64'(pc_en), 64'd1);
    nxt(); load_to(5'd9); id_rsel1 = 5'd3; id_rsel2 = 5'd9; id_uses_rs2 = 1'b1;
    smp(); chk("rt_used", 64'(pc_en), 64'd0); chk("rt_idex_flush", 64'(idex_flush), 64'd1);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      nxt(); mem_dreq = 1'b1;
      smp(); chk("dw_pc_en", 64'(pc_en), 64'd0); chk("dw_memwb_en", 64'(memwb_en), 64'd0);
      chk("dw_memwb_flush", 64'(memwb_flush), 64'd1);
      chk("dw_state", 64'(hz_state), (i == 0) ? 64'd0 : 64'd2);
    end
    nxt(); mem_dreq = 1'b1; dhit = 1'b1;
    smp(); chk("dw_resume", 64'(pc_en), 64'd1); chk("dw_stall", 64'(stall_cnt), 64'd3);

    do_reset();
    nxt(); mem_dreq = 1'b1; mem_br_taken = 1'b1;
    smp(); chk("defer_no_flush", 64'(ifid_flush), 64'd0); chk("defer_wait", 64'(pc_en), 64'd0);
    nxt(); mem_dreq = 1'b1; dhit = 1'b1;
    smp(); chk("defer_flush", 64'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 64'hE);
    chk("defer_pc_en", 64'(pc_en), 64'd1);
    nxt();
    smp(); chk("defer_cnt", 64'(flush_cnt), 64'd1); chk("defer_once", 64'(ifid_flush), 64'd0);
    chk("defer_state", 64'(hz_state), 64'd3);

    do_reset();
    repeat (20) begin nxt(); ihit = 1'b0; end
    nxt();
    smp(); chk("sat_stall4", 64'(stall_cnt4), 64'd15); chk("sat_stall32", 64'(stall_cnt), 64'd20);

    for (int i = 0; i < 3000; i++) begin
      nxt();
      RST          = ($urandom_range(0, 63) == 0);
      id_rsel1     = 5'($urandom_range(0, 3));
      id_rsel2     = 5'($urandom_range(0, 3));
      id_uses_rs2  = 1'($urandom_range(0, 1));
      ex_wsel      = 5'($urandom_range(0, 3));
      ex_wen       = ($urandom_range(0, 3) != 0);
      ex_memToReg  = 1'($urandom_range(0, 1));
      mem_dreq     = ($urandom_range(0, 9) < 3);
      dhit         = 1'($urandom_range(0, 1));
      ihit         = ($urandom_range(0, 4) != 0);
      mem_br_taken = ($urandom_range(0, 6) == 0);
    end
    nxt();
    smp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
